// File: rtl/dff.sv
// Enabled D register with synchronous active-high reset; STAGES > 1 chains identical
// enabled stages into a delay line that only advances on enabled edges.
module dff #(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // The whole chain shifts as one on an enabled edge, otherwise every stage holds.
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VALUE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: a default single-stage 8-bit instance and a
// 4-bit, three-stage instance with a non-zero reset value.
module tb_dff;

    logic       clk;
    logic       rst_a, en_a;
    logic [7:0] d_a, q_a;
    logic       rst_b, en_b;
    logic [3:0] d_b, q_b;

    int checks;
    int errors;

    dff u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .en  (en_a),
        .d   (d_a),
        .q   (q_a)
    );

    dff #(
        .WIDTH       (4),
        .RESET_VALUE (4'h9),
        .STAGES      (3)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .en  (en_b),
        .d   (d_b),
        .q   (q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        en_a  = 1'b1;
        d_a   = 8'hAA;
        @(posedge clk);
        tick();
        checks++;
        if (q_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_over_en: got %h want %h", q_a, 8'h00);
        end
    endtask

    task automatic test_load();
        logic [7:0] vals [2] = '{8'hFF, 8'hA0};
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_a = vals[i];
            tick();
            checks++;
            if (q_a !== vals[i]) begin
                errors++;
                $display("FAIL load_%0d: got %h want %h", i, q_a, vals[i]);
            end
        end
    endtask

    task automatic test_hold();
        en_a = 1'b0;
        d_a  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q_a !== 8'hA0) begin
                errors++;
                $display("FAIL hold_%0d: got %h want %h", i, q_a, 8'hA0);
            end
        end
        en_a = 1'b1;
        tick();
        checks++;
        if (q_a !== 8'h55) begin
            errors++;
            $display("FAIL hold_release: got %h want %h", q_a, 8'h55);
        end
    endtask

    task automatic test_sync_reset();
        en_a = 1'b0;
        #2 rst_a = 1'b1;
        #3;
        checks++;
        if (q_a !== 8'h55) begin
            errors++;
            $display("FAIL glitch_during: got %h want %h", q_a, 8'h55);
        end
        rst_a = 1'b0;
        tick();
        checks++;
        if (q_a !== 8'h55) begin
            errors++;
            $display("FAIL glitch_after_edge: got %h want %h", q_a, 8'h55);
        end
        rst_a = 1'b1;
        tick();
        checks++;
        if (q_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_en_low: got %h want %h", q_a, 8'h00);
        end
        rst_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h3C, 8'hC3, 8'h01};
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_a = vals[i];
            tick();
            checks++;
            if (q_a !== vals[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got %h want %h", i, q_a, vals[i]);
            end
        end
        // X on d is ignored while disabled.
        en_a = 1'b0;
        d_a  = 8'hxx;
        tick();
        checks++;
        if (q_a !== 8'h01) begin
            errors++;
            $display("FAIL x_while_disabled: got %h want %h", q_a, 8'h01);
        end
    endtask

    task automatic test_param_latency();
        logic [3:0] din  [3] = '{4'h1, 4'h2, 4'h3};
        logic [3:0] qexp [3] = '{4'h9, 4'h9, 4'h1};
        rst_b = 1'b1;
        en_b  = 1'b0;
        d_b   = 4'h0;
        tick();
        checks++;
        if (q_b !== 4'h9) begin
            errors++;
            $display("FAIL p_reset: got %h want %h", q_b, 4'h9);
        end
        rst_b = 1'b0;
        en_b  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_b = din[i];
            tick();
            checks++;
            if (q_b !== qexp[i]) begin
                errors++;
                $display("FAIL p_fill_%0d: got %h want %h", i, q_b, qexp[i]);
            end
        end
    endtask

    task automatic test_param_bubble();
        logic       ens  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] din  [4] = '{4'hF, 4'h4, 4'h5, 4'h6};
        logic [3:0] qexp [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 4; i++) begin
            en_b = ens[i];
            d_b  = din[i];
            tick();
            checks++;
            if (q_b !== qexp[i]) begin
                errors++;
                $display("FAIL p_bubble_%0d: got %h want %h", i, q_b, qexp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic       rsts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] din  [5] = '{4'h7, 4'h8, 4'hA, 4'hB, 4'hC};
        logic [3:0] qexp [5] = '{4'h5, 4'h9, 4'h9, 4'h9, 4'hA};
        en_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rst_b = rsts[i];
            d_b   = din[i];
            tick();
            checks++;
            if (q_b !== qexp[i]) begin
                errors++;
                $display("FAIL p_midreset_%0d: got %h want %h", i, q_b, qexp[i]);
            end
        end
        rst_b = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_b  = 1'b0;
        en_b   = 1'b0;
        d_b    = 4'h0;
        test_reset();
        test_load();
        test_hold();
        test_sync_reset();
        test_back_to_back();
        test_param_latency();
        test_param_bubble();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
